// File: rtl/params_pkg.sv
// Shared parameters and FSM state type for the BCM row scan scheduler.
package params_pkg;
  localparam int BRIGHTNESS_LEVELS = 8;
  localparam int PIXEL_HEIGHT      = 16;

  // state | meaning
  // IDLE  | scan stopped, outputs hold last displayed row/plane
  // PRIME | first shift of a scan in flight, nothing displayed yet
  // LATCH | row_latch pulse cycle, plane counter steps
  // RUN   | plane displayed, waiting for next shift and on-time expiry
  typedef enum logic [1:0] {IDLE, PRIME, LATCH, RUN} sched_state_t;
endpackage

// File: rtl/bcm_plane_counter.sv
// Steps the one-hot bit-plane mask MSB to LSB, then advances the row with wrap.
module bcm_plane_counter #(
  parameter int LEVELS = 8,
  parameter int HEIGHT = 16,
  parameter int ROW_W  = $clog2(HEIGHT)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_advance,
  output logic [LEVELS-1:0] o_mask,
  output logic [ROW_W-1:0]  o_row,
  output logic              o_wrap
);
  localparam logic [LEVELS-1:0] MASK_MSB = {1'b1, {(LEVELS-1){1'b0}}};
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT-1);

  logic [LEVELS-1:0] r_mask;
  logic [ROW_W-1:0]  r_row;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mask <= MASK_MSB;
      r_row  <= '0;
    end else if (i_advance) begin
      if (r_mask[0]) begin
        r_mask <= MASK_MSB;
        r_row  <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_mask <= r_mask >> 1;
      end
    end
  end

  assign o_mask = r_mask;
  assign o_row  = r_row;
  // Current load is the final plane of the final row of a frame.
  assign o_wrap = r_mask[0] && (r_row == ROW_LAST);
endmodule

// File: rtl/bcm_row_scheduler.sv
// Sequences shift, latch and on-time handshakes for a binary-coded-modulation row scan.
module bcm_row_scheduler
  import params_pkg::*;
#(
  parameter int BRIGHTNESS_LEVELS = params_pkg::BRIGHTNESS_LEVELS,
  parameter int PIXEL_HEIGHT      = params_pkg::PIXEL_HEIGHT
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            shift_done,
  input  logic                            exceeded_overlap_time,
  output logic                            shift_start,
  output logic [$clog2(PIXEL_HEIGHT)-1:0] load_row,
  output logic [BRIGHTNESS_LEVELS-1:0]    load_mask,
  output logic                            row_latch,
  output logic [$clog2(PIXEL_HEIGHT)-1:0] row_address,
  output logic [BRIGHTNESS_LEVELS-1:0]    brightness_mask_active,
  output logic                            frame_done
);
  localparam int ROW_W = $clog2(PIXEL_HEIGHT);
  localparam logic [BRIGHTNESS_LEVELS-1:0] MASK_MSB = {1'b1, {(BRIGHTNESS_LEVELS-1){1'b0}}};

  sched_state_t r_state;
  logic         r_sd_flag;
  logic         r_ex_flag;
  logic         w_sd_seen;
  logic         w_ex_seen;
  logic         w_advance;
  logic         w_wrap;

  assign w_sd_seen = r_sd_flag | shift_done;
  assign w_ex_seen = r_ex_flag | exceeded_overlap_time;
  assign w_advance = (r_state == LATCH);

  bcm_plane_counter #(
    .LEVELS (BRIGHTNESS_LEVELS),
    .HEIGHT (PIXEL_HEIGHT),
    .ROW_W  (ROW_W)
  ) u_plane_counter (
    .i_clk     (clk_in),
    .i_reset   (reset),
    .i_advance (w_advance),
    .o_mask    (load_mask),
    .o_row     (load_row),
    .o_wrap    (w_wrap)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state                <= IDLE;
      r_sd_flag              <= 1'b0;
      r_ex_flag              <= 1'b0;
      shift_start            <= 1'b0;
      row_latch              <= 1'b0;
      frame_done             <= 1'b0;
      row_address            <= '0;
      brightness_mask_active <= MASK_MSB;
    end else begin
      shift_start <= 1'b0;
      row_latch   <= 1'b0;
      frame_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            shift_start <= 1'b1;
            r_state     <= PRIME;
          end
        end
        PRIME: begin
          if (shift_done) begin
            if (enable) begin
              r_state                <= LATCH;
              row_latch              <= 1'b1;
              row_address            <= load_row;
              brightness_mask_active <= load_mask;
              frame_done             <= w_wrap;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        LATCH: begin
          r_state     <= RUN;
          shift_start <= 1'b1;
        end
        RUN: begin
          // Stopping waits for the displayed plane to finish its on-time.
          if (!enable && w_ex_seen) begin
            r_state   <= IDLE;
            r_sd_flag <= 1'b0;
            r_ex_flag <= 1'b0;
          end else if (w_sd_seen && w_ex_seen) begin
            r_state                <= LATCH;
            r_sd_flag              <= 1'b0;
            r_ex_flag              <= 1'b0;
            row_latch              <= 1'b1;
            row_address            <= load_row;
            brightness_mask_active <= load_mask;
            frame_done             <= w_wrap;
          end else begin
            r_sd_flag <= w_sd_seen;
            r_ex_flag <= w_ex_seen;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcm_row_scheduler.sv
// Directed bench for bcm_row_scheduler with a behavioural shifter and brightness timeout.
module tb_bcm_row_scheduler;
  localparam int BL = 4;
  localparam int PH = 4;

  logic          clk_in = 1'b0;
  logic          reset, enable, sd_man, ex_man, auto_en;
  logic          sd_auto, tm_active;
  int            tm_cnt, base;
  logic          shift_done, exceeded_overlap_time;
  logic          shift_start, row_latch, frame_done;
  logic [1:0]    load_row, row_address;
  logic [BL-1:0] load_mask, brightness_mask_active;
  int            tests = 0;
  int            fails = 0;

  always #5 clk_in = ~clk_in;

  assign shift_done            = sd_man | sd_auto;
  assign exceeded_overlap_time = ex_man | (auto_en & tm_active & (tm_cnt == 0));

  bcm_row_scheduler #(.BRIGHTNESS_LEVELS(BL), .PIXEL_HEIGHT(PH)) dut (
    .clk_in                 (clk_in),
    .reset                  (reset),
    .enable                 (enable),
    .shift_done             (shift_done),
    .exceeded_overlap_time  (exceeded_overlap_time),
    .shift_start            (shift_start),
    .load_row               (load_row),
    .load_mask              (load_mask),
    .row_latch              (row_latch),
    .row_address            (row_address),
    .brightness_mask_active (brightness_mask_active),
    .frame_done             (frame_done)
  );

  // Shifter answers one cycle after shift_start; timeout runs base*weight cycles per plane.
  always @(posedge clk_in) begin
    if (reset) begin
      sd_auto   <= 1'b0;
      tm_active <= 1'b0;
      tm_cnt    <= 0;
    end else begin
      sd_auto <= auto_en & shift_start;
      if (row_latch) begin
        tm_active <= 1'b1;
        tm_cnt    <= base * int'(brightness_mask_active);
      end else if (tm_cnt != 0) begin
        tm_cnt <= tm_cnt - 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; sd_man = 1'b0; ex_man = 1'b0; auto_en = 1'b0; base = 1;
    tick(); tick();
    tests++; if ({shift_start, row_latch, frame_done} !== 3'b000) begin
      fails++; $display("FAIL reset_pulses got=%b exp=000", {shift_start, row_latch, frame_done});
    end
    tests++; if (row_address !== 2'd0 || load_row !== 2'd0) begin
      fails++; $display("FAIL reset_rows got=%0d/%0d exp=0/0", row_address, load_row);
    end
    tests++; if (brightness_mask_active !== 4'b1000 || load_mask !== 4'b1000) begin
      fails++; $display("FAIL reset_masks got=%b/%b exp=1000/1000", brightness_mask_active, load_mask);
    end
  endtask

  task automatic test_startup();
    reset = 1'b0; enable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      tests++; if (shift_start !== (c == 1 || c == 7)) begin
        fails++; $display("FAIL startup_shift_start cycle=%0d got=%b", c, shift_start);
      end
      tests++; if (row_latch !== (c == 6)) begin
        fails++; $display("FAIL startup_row_latch cycle=%0d got=%b", c, row_latch);
      end
      if (c == 6) begin
        tests++; if (row_address !== 2'd0 || brightness_mask_active !== 4'b1000) begin
          fails++; $display("FAIL startup_latched got=%0d/%b exp=0/1000", row_address, brightness_mask_active);
        end
      end
      if (c == 7) begin
        tests++; if (load_mask !== 4'b0100) begin
          fails++; $display("FAIL startup_load_mask got=%b exp=0100", load_mask);
        end
      end
      sd_man = (c == 5);
    end
    sd_man = 1'b0;
  endtask

  task automatic test_simultaneous();
    int n = 0;
    sd_man = 1'b1; ex_man = 1'b1;
    tick();
    sd_man = 1'b0; ex_man = 1'b0;
    tests++; if (row_latch !== 1'b1 || brightness_mask_active !== 4'b0100 || frame_done !== 1'b0) begin
      fails++; $display("FAIL simul_latch got=%b/%b/%b exp=1/0100/0", row_latch, brightness_mask_active, frame_done);
    end
    repeat (5) begin tick(); if (row_latch) n++; end
    tests++; if (n != 0) begin
      fails++; $display("FAIL simul_extra_latch got=%0d exp=0", n);
    end
  endtask

  task automatic test_exceeded_first();
    int n = 0;
    ex_man = 1'b1;
    repeat (10) begin tick(); if (row_latch) n++; end
    tests++; if (n != 0) begin
      fails++; $display("FAIL early_latch got=%0d exp=0", n);
    end
    sd_man = 1'b1;
    tick();
    sd_man = 1'b0; ex_man = 1'b0;
    tests++; if (row_latch !== 1'b1 || brightness_mask_active !== 4'b0010) begin
      fails++; $display("FAIL late_sd_latch got=%b/%b exp=1/0010", row_latch, brightness_mask_active);
    end
    tick();
    tests++; if (row_latch !== 1'b0) begin
      fails++; $display("FAIL late_sd_single got=%b exp=0", row_latch);
    end
  endtask

  task automatic test_enable_off();
    int n = 0;
    enable = 1'b0;
    sd_man = 1'b1; tick(); sd_man = 1'b0; tick();
    sd_man = 1'b1; tick(); sd_man = 1'b0;
    repeat (3) begin tick(); if (row_latch) n++; end
    ex_man = 1'b1; tick(); ex_man = 1'b0;
    repeat (5) begin tick(); if (row_latch || shift_start) n++; end
    tests++; if (n != 0) begin
      fails++; $display("FAIL stop_activity got=%0d exp=0", n);
    end
    tests++; if (row_address !== 2'd0 || brightness_mask_active !== 4'b0010) begin
      fails++; $display("FAIL stop_hold_display got=%0d/%b exp=0/0010", row_address, brightness_mask_active);
    end
    tests++; if (load_row !== 2'd0 || load_mask !== 4'b0001) begin
      fails++; $display("FAIL stop_hold_load got=%0d/%b exp=0/0001", load_row, load_mask);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    tick();
    tests++; if (shift_start !== 1'b1) begin
      fails++; $display("FAIL restart_shift got=%b exp=1", shift_start);
    end
    sd_man = 1'b1; tick(); sd_man = 1'b0;
    tests++; if (row_latch !== 1'b1 || brightness_mask_active !== 4'b0001) begin
      fails++; $display("FAIL restart_lsb got=%b/%b exp=1/0001", row_latch, brightness_mask_active);
    end
    tick();
    tests++; if (load_row !== 2'd1 || load_mask !== 4'b1000 || shift_start !== 1'b1) begin
      fails++; $display("FAIL row_step got=%0d/%b/%b exp=1/1000/1", load_row, load_mask, shift_start);
    end
    reset = 1'b1; sd_man = 1'b1; ex_man = 1'b1;
    tick();
    reset = 1'b0; sd_man = 1'b0; ex_man = 1'b0;
    tests++; if ({shift_start, row_latch, frame_done} !== 3'b000 || row_address !== 2'd0 || load_row !== 2'd0) begin
      fails++; $display("FAIL midreset_ctrl got=%b rows=%0d/%0d exp=000 0/0",
                        {shift_start, row_latch, frame_done}, row_address, load_row);
    end
    tests++; if (brightness_mask_active !== 4'b1000 || load_mask !== 4'b1000) begin
      fails++; $display("FAIL midreset_masks got=%b/%b exp=1000/1000", brightness_mask_active, load_mask);
    end
    tick();
    tests++; if (shift_start !== 1'b1 || row_latch !== 1'b0) begin
      fails++; $display("FAIL midreset_restart got=%b/%b exp=1/0", shift_start, row_latch);
    end
    sd_man = 1'b1; tick(); sd_man = 1'b0;
    tests++; if (row_latch !== 1'b1 || row_address !== 2'd0 || brightness_mask_active !== 4'b1000) begin
      fails++; $display("FAIL midreset_first_latch got=%b/%0d/%b exp=1/0/1000",
                        row_latch, row_address, brightness_mask_active);
    end
  endtask

  task automatic test_frame();
    int n = 0;
    int frames = 0;
    int bad = 0;
    logic [3:0] exp_m;
    reset = 1'b1; enable = 1'b0; auto_en = 1'b1; base = 1;
    tick(); tick();
    reset = 1'b0; enable = 1'b1;
    for (int c = 0; c < 600 && n < 32; c++) begin
      tick();
      if (frame_done) frames++;
      if (frame_done && !row_latch) bad++;
      if (row_latch) begin
        exp_m = 4'b1000 >> (n % 4);
        tests++; if (row_address !== 2'((n / 4) % 4) || brightness_mask_active !== exp_m
                     || frame_done !== (n % 16 == 15)) begin
          fails++; $display("FAIL frame_seq latch=%0d got=%0d/%b/%b exp=%0d/%b/%b", n, row_address,
                            brightness_mask_active, frame_done, (n / 4) % 4, exp_m, (n % 16 == 15));
        end
        n++;
      end
    end
    tests++; if (n != 32) begin
      fails++; $display("FAIL frame_latch_count got=%0d exp=32", n);
    end
    tests++; if (frames != 2 || bad != 0) begin
      fails++; $display("FAIL frame_done_count got=%0d stray=%0d exp=2/0", frames, bad);
    end
  endtask

  task automatic test_closed_loop();
    int t[5];
    int n = 0;
    int oh_bad = 0;
    reset = 1'b1; enable = 1'b0; auto_en = 1'b1; base = 23;
    tick(); tick();
    reset = 1'b0; enable = 1'b1;
    for (int c = 0; c < 2000 && n < 5; c++) begin
      tick();
      if (!$onehot(brightness_mask_active) || !$onehot(load_mask)) oh_bad++;
      if (row_latch) begin t[n] = c; n++; end
    end
    tests++; if (n != 5) begin
      fails++; $display("FAIL loop_latch_count got=%0d exp=5", n);
    end else begin
      tests++; if ((t[1] - t[0]) - (t[2] - t[1]) != 92 || (t[2] - t[1]) - (t[3] - t[2]) != 46
                   || (t[3] - t[2]) - (t[4] - t[3]) != 23) begin
        fails++; $display("FAIL loop_halving got=%0d,%0d,%0d,%0d exp=186,94,48,25",
                          t[1] - t[0], t[2] - t[1], t[3] - t[2], t[4] - t[3]);
      end
      tests++; if (t[4] - t[3] != 25) begin
        fails++; $display("FAIL loop_lsb_interval got=%0d exp=25", t[4] - t[3]);
      end
    end
    tests++; if (oh_bad != 0) begin
      fails++; $display("FAIL loop_onehot got=%0d bad cycles exp=0", oh_bad);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_simultaneous();
    test_exceeded_first();
    test_enable_off();
    test_reset_mid();
    test_frame();
    test_closed_loop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
